// File: rtl/vga_chk_pkg.sv
// vga_chk_pkg: shared types and default VGA timing for the frame checker.
//   chk_state_e  - checker FSM states
//   DEF_*        - 640x480@60 timing shared with the solo_squash sync generator
//   cksum_step   - one step of the per-frame colour checksum
package vga_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int unsigned DEF_H_TOTAL      = 32'd800;
  localparam int unsigned DEF_H_SYNC_START = 32'd656;
  localparam int unsigned DEF_H_SYNC_LEN   = 32'd96;
  localparam int unsigned DEF_V_TOTAL      = 32'd525;
  localparam int unsigned DEF_V_SYNC_START = 32'd490;
  localparam int unsigned DEF_V_SYNC_LEN   = 32'd2;
  localparam int unsigned DEF_H_VISIBLE    = 32'd640;
  localparam int unsigned DEF_V_VISIBLE    = 32'd480;
  localparam logic        DEF_SYNC_ACT_LOW = 1'b1;
  localparam int unsigned DEF_LOCK_FRAMES  = 32'd1;

  // Rotate left by one, then fold in the 3-bit pixel.
  function automatic logic [15:0] cksum_step(input logic [15:0] cksum, input logic [2:0] pix);
    cksum_step = {cksum[14:0], cksum[15]} ^ {13'b0, pix};
  endfunction

endpackage

// File: rtl/vga_pos_tracker.sv
// vga_pos_tracker: reconstructed raster position and expected sync decode.
//   clk, rst_n     - pixel clock, async active-low reset
//   load           - the current sample is pixel (0,0); restart counting there
//   advance        - the current sample is the successor of (h_pos, v_pos)
//   h_pos, v_pos   - registered position of the previous sample
//   exp_*          - what col0/row0/hs/vs should be for the current sample
//   samp_visible   - current sample lies in the visible area
//   samp_last      - current sample is the last pixel of the frame
module vga_pos_tracker
  import vga_chk_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter int unsigned H_VISIBLE    = DEF_H_VISIBLE,
  parameter int unsigned V_VISIBLE    = DEF_V_VISIBLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       exp_col0,
  output logic       exp_row0,
  output logic       exp_hs,
  output logic       exp_vs,
  output logic       samp_visible,
  output logic       samp_last
);

  logic       h_wrap_s;
  logic       v_wrap_s;
  logic [9:0] samp_h_s;
  logic [9:0] samp_v_s;

  // Position of the current sample (successor of the registered one) and its expected markers.
  always_comb begin
    h_wrap_s = (h_pos == 10'(H_TOTAL - 32'd1));
    v_wrap_s = (v_pos == 10'(V_TOTAL - 32'd1));
    samp_h_s = h_pos;
    samp_v_s = v_pos;
    if (load) begin
      samp_h_s = 10'd0;
      samp_v_s = 10'd0;
    end else if (h_wrap_s) begin
      samp_h_s = 10'd0;
      if (v_wrap_s) begin
        samp_v_s = 10'd0;
      end else begin
        samp_v_s = v_pos + 10'd1;
      end
    end else begin
      samp_h_s = h_pos + 10'd1;
      samp_v_s = v_pos;
    end
    exp_col0     = (samp_h_s == 10'd0);
    exp_row0     = (samp_v_s == 10'd0);
    exp_hs       = (samp_h_s >= 10'(H_SYNC_START)) &&
                   (samp_h_s <  10'(H_SYNC_START + H_SYNC_LEN));
    exp_vs       = (samp_v_s >= 10'(V_SYNC_START)) &&
                   (samp_v_s <  10'(V_SYNC_START + V_SYNC_LEN));
    samp_visible = (samp_h_s < 10'(H_VISIBLE)) && (samp_v_s < 10'(V_VISIBLE));
    samp_last    = (samp_h_s == 10'(H_TOTAL - 32'd1)) && (samp_v_s == 10'(V_TOTAL - 32'd1));
  end

  // Position register; holds while the checker is hunting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos <= 10'd0;
      v_pos <= 10'd0;
    end else if (load || advance) begin
      h_pos <= samp_h_s;
      v_pos <= samp_v_s;
    end else begin
      h_pos <= h_pos;
      v_pos <= v_pos;
    end
  end

endmodule

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: receive-side monitor for the solo_squash VGA output.
//   Inputs : clk, rst_n, red/green/blue, hsync/vsync, col0, row0, speaker, clear_err
//   Outputs: h_pos/v_pos (reconstructed position), locked, frame_done, frame_count,
//            frame_cksum/lit_count/spk_toggles (last frame), sticky err_line/err_frame/
//            err_hsync/err_vsync. All outputs are registered.
module vga_frame_checker
  import vga_chk_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter int unsigned H_VISIBLE    = DEF_H_VISIBLE,
  parameter int unsigned V_VISIBLE    = DEF_V_VISIBLE,
  parameter logic        SYNC_ACT_LOW = DEF_SYNC_ACT_LOW,
  parameter int unsigned LOCK_FRAMES  = DEF_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        col0,
  input  logic        row0,
  input  logic        speaker,
  input  logic        clear_err,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic [15:0] frame_cksum,
  output logic [18:0] lit_count,
  output logic [15:0] spk_toggles,
  output logic        err_line,
  output logic        err_frame,
  output logic        err_hsync,
  output logic        err_vsync
);

  chk_state_e  state_r, state_nxt_s;
  logic        hs_s, vs_s;
  logic        capture_s, tracking_s, accum_s, frame_end_s;
  logic        exp_col0_s, exp_row0_s, exp_hs_s, exp_vs_s, samp_visible_s, samp_last_s;
  logic        e_line_s, e_frame_s, e_hs_s, e_vs_s, any_err_s;
  logic [2:0]  pix_s;
  logic        pix_on_s, spk_edge_s;
  logic [15:0] cksum_acc_r, cksum_base_s, cksum_new_s;
  logic [18:0] lit_acc_r, lit_base_s, lit_new_s;
  logic [15:0] spk_acc_r, spk_base_s, spk_new_s;
  logic        spk_last_r;
  logic [7:0]  clean_cnt_r;

  vga_pos_tracker #(
    .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN),
    .V_TOTAL(V_TOTAL), .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN),
    .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE)
  ) u_pos (
    .clk(clk), .rst_n(rst_n), .load(capture_s), .advance(tracking_s),
    .h_pos(h_pos), .v_pos(v_pos),
    .exp_col0(exp_col0_s), .exp_row0(exp_row0_s), .exp_hs(exp_hs_s), .exp_vs(exp_vs_s),
    .samp_visible(samp_visible_s), .samp_last(samp_last_s)
  );

  // Per-sample checks and next values of the frame accumulators.
  always_comb begin
    hs_s        = hsync ^ SYNC_ACT_LOW;
    vs_s        = vsync ^ SYNC_ACT_LOW;
    capture_s   = (state_r == HUNT) && col0 && row0;
    tracking_s  = (state_r != HUNT);
    accum_s     = capture_s || tracking_s;
    frame_end_s = tracking_s && samp_last_s;
    e_line_s    = tracking_s && (col0 != exp_col0_s);
    e_frame_s   = tracking_s && (row0 != exp_row0_s);
    e_hs_s      = tracking_s && (hs_s != exp_hs_s);
    e_vs_s      = tracking_s && (vs_s != exp_vs_s);
    any_err_s   = e_line_s || e_frame_s || e_hs_s || e_vs_s;
    pix_s       = {red, green, blue};
    pix_on_s    = accum_s && samp_visible_s;
    spk_edge_s  = (speaker != spk_last_r);
    // The capture sample is pixel (0,0): it starts a fresh frame rather than adding to stale totals.
    cksum_base_s = capture_s ? 16'h0000 : cksum_acc_r;
    lit_base_s   = capture_s ? 19'd0 : lit_acc_r;
    spk_base_s   = capture_s ? 16'h0000 : spk_acc_r;
    if (pix_on_s) begin
      cksum_new_s = cksum_step(cksum_base_s, pix_s);
    end else begin
      cksum_new_s = cksum_base_s;
    end
    if (pix_on_s && (pix_s != 3'b000)) begin
      lit_new_s = lit_base_s + 19'd1;
    end else begin
      lit_new_s = lit_base_s;
    end
    if (spk_edge_s && (spk_base_s != 16'hFFFF)) begin
      spk_new_s = spk_base_s + 16'd1;
    end else begin
      spk_new_s = spk_base_s;
    end
  end

  // FSM next state: any mismatch while tracking sends the checker back to hunting.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HUNT: begin
        if (capture_s) state_nxt_s = TRACK;
        else           state_nxt_s = HUNT;
      end
      TRACK: begin
        if (any_err_s) begin
          state_nxt_s = HUNT;
        end else if (frame_end_s && ((32'(clean_cnt_r) + 32'd1) >= LOCK_FRAMES)) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = TRACK;
        end
      end
      LOCKED: begin
        if (any_err_s) state_nxt_s = HUNT;
        else           state_nxt_s = LOCKED;
      end
      default: state_nxt_s = HUNT;
    endcase
  end

  // FSM state register, lock indicator and clean-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      locked      <= 1'b0;
      clean_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      locked  <= (state_nxt_s == LOCKED);
      if (capture_s) begin
        clean_cnt_r <= 8'd0;
      end else if (frame_end_s && !any_err_s && (clean_cnt_r != 8'hFF)) begin
        clean_cnt_r <= clean_cnt_r + 8'd1;
      end else begin
        clean_cnt_r <= clean_cnt_r;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      err_hsync <= 1'b0;
      err_vsync <= 1'b0;
    end else begin
      err_line  <= e_line_s  || (err_line  && !clear_err);
      err_frame <= e_frame_s || (err_frame && !clear_err);
      err_hsync <= e_hs_s    || (err_hsync && !clear_err);
      err_vsync <= e_vs_s    || (err_vsync && !clear_err);
    end
  end

  // Frame accumulators and end-of-frame result latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_last_r  <= 1'b0;
      cksum_acc_r <= 16'h0000;
      lit_acc_r   <= 19'd0;
      spk_acc_r   <= 16'h0000;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      frame_cksum <= 16'h0000;
      lit_count   <= 19'd0;
      spk_toggles <= 16'h0000;
    end else begin
      spk_last_r <= speaker;
      frame_done <= frame_end_s;
      if (frame_end_s) begin
        frame_cksum <= cksum_new_s;
        lit_count   <= lit_new_s;
        spk_toggles <= spk_new_s;
        frame_count <= frame_count + 8'd1;
        cksum_acc_r <= 16'h0000;
        lit_acc_r   <= 19'd0;
        spk_acc_r   <= 16'h0000;
      end else if (accum_s) begin
        cksum_acc_r <= cksum_new_s;
        lit_acc_r   <= lit_new_s;
        spk_acc_r   <= spk_new_s;
      end else begin
        cksum_acc_r <= cksum_acc_r;
        lit_acc_r   <= lit_acc_r;
        spk_acc_r   <= spk_acc_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker using a shrunken raster (20x12 clocks, 12x8 visible).
module tb_vga_frame_checker;

  localparam int HT = 20, HSS = 14, HSL = 3, HV = 12;
  localparam int VT = 12, VSS = 9,  VSL = 2, VV = 8;
  localparam int FRAME = HT * VT;

  logic clk, rst_n, red, green, blue, hsync, vsync, col0, row0, speaker, clear_err;
  logic [9:0]  h_pos, v_pos;
  logic        locked, frame_done, err_line, err_frame, err_hsync, err_vsync;
  logic [7:0]  frame_count;
  logic [15:0] frame_cksum, spk_toggles;
  logic [18:0] lit_count;

  int   n_vec, n_err;
  int   gh, gv, rgb_mode, hs_start, short_v;
  logic spk_level;

  vga_frame_checker #(
    .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .H_VISIBLE(HV), .V_VISIBLE(VV), .SYNC_ACT_LOW(1'b1), .LOCK_FRAMES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .col0(col0), .row0(row0), .speaker(speaker),
    .clear_err(clear_err), .h_pos(h_pos), .v_pos(v_pos), .locked(locked),
    .frame_done(frame_done), .frame_count(frame_count), .frame_cksum(frame_cksum),
    .lit_count(lit_count), .spk_toggles(spk_toggles), .err_line(err_line),
    .err_frame(err_frame), .err_hsync(err_hsync), .err_vsync(err_vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] pix_at(int mode, int h, int v);
    if (mode == 1) return 3'b111;
    return 3'((h ^ v) & 7);
  endfunction

  function automatic logic [15:0] model_cksum(int mode);
    logic [15:0] c;
    logic [2:0]  p;
    c = 16'h0000;
    for (int v = 0; v < VV; v++)
      for (int h = 0; h < HV; h++) begin
        p = pix_at(mode, h, v);
        c = {c[14:0], c[15]} ^ {13'b0, p};
      end
    return c;
  endfunction

  function automatic int model_lit(int mode);
    int n;
    n = 0;
    for (int v = 0; v < VV; v++)
      for (int h = 0; h < HV; h++)
        if (pix_at(mode, h, v) != 3'b000) n++;
    return n;
  endfunction

  // Drive the pixel at (gh,gv), let the DUT sample it, return at the following negedge.
  task automatic step();
    logic [2:0] p;
    col0  = (gh == 0);
    row0  = (gv == 0);
    hsync = !((gh >= hs_start) && (gh < hs_start + HSL));
    vsync = !((gv >= VSS) && (gv < VSS + VSL));
    p = (gh < HV && gv < VV) ? pix_at(rgb_mode, gh, gv) : 3'b000;
    {red, green, blue} = p;
    speaker = spk_level;
    @(negedge clk);
    gh++;
    if (gh >= ((gv == short_v) ? HT - 1 : HT)) begin
      gh = 0;
      gv++;
      if (gv == VT) gv = 0;
    end
  endtask

  task automatic run_to_origin(output int pulses);
    int n;
    pulses = 0;
    n = 0;
    while (!(gh == 0 && gv == 0) && n < 2 * FRAME) begin
      step();
      if (frame_done) pulses++;
      n++;
    end
    n_vec++;
    if (!(gh == 0 && gv == 0)) begin
      n_err++;
      $display("FAIL origin_reach: generator at %0d,%0d want 0,0", gh, gv);
    end
  endtask

  task automatic run_frame(input bit toggles, output int pulses);
    pulses = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (toggles && (i == 30 || i == 31 || i == 50 || i == 100 || i == 150))
        spk_level = ~spk_level;
      step();
      if (frame_done) pulses++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({h_pos, v_pos, locked, frame_done, frame_count, frame_cksum, lit_count, spk_toggles,
         err_line, err_frame, err_hsync, err_vsync} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: h=%0d v=%0d locked=%0b fc=%0d want all 0", h_pos, v_pos, locked, frame_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_game();
    int pulses;
    run_to_origin(pulses);
    n_vec++;
    if (pulses != 0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL hunt_idle: pulses=%0d locked=%0b want 0/0", pulses, locked);
    end
    run_frame(1'b0, pulses);
    n_vec++;
    if (pulses != 1 || frame_done !== 1'b1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL lock_first_frame: pulses=%0d done=%0b locked=%0b want 1/1/1", pulses, frame_done, locked);
    end
    n_vec++;
    if (frame_count !== 8'd1) begin
      n_err++;
      $display("FAIL frame_count_1: got %0d want 1", frame_count);
    end
    run_frame(1'b0, pulses);
    n_vec++;
    if (frame_count !== 8'd2 || pulses != 1) begin
      n_err++;
      $display("FAIL frame_count_2: got %0d pulses=%0d want 2/1", frame_count, pulses);
    end
    n_vec++;
    if ({err_line, err_frame, err_hsync, err_vsync} !== 4'b0000) begin
      n_err++;
      $display("FAIL game_no_err: got %b want 0000", {err_line, err_frame, err_hsync, err_vsync});
    end
    n_vec++;
    if (frame_cksum !== model_cksum(0) || lit_count !== 19'(model_lit(0))) begin
      n_err++;
      $display("FAIL pattern_result: cksum=%h lit=%0d want %h/%0d", frame_cksum, lit_count, model_cksum(0), model_lit(0));
    end
    n_vec++;
    if (spk_toggles !== 16'd0) begin
      n_err++;
      $display("FAIL quiet_speaker: got %0d want 0", spk_toggles);
    end
  endtask

  task automatic test_white_frame();
    int pulses;
    rgb_mode = 1;
    run_frame(1'b0, pulses);
    rgb_mode = 0;
    n_vec++;
    if (lit_count !== 19'(HV * VV)) begin
      n_err++;
      $display("FAIL white_lit: got %0d want %0d", lit_count, HV * VV);
    end
    n_vec++;
    if (frame_cksum !== model_cksum(1)) begin
      n_err++;
      $display("FAIL white_cksum: got %h want %h", frame_cksum, model_cksum(1));
    end
  endtask

  task automatic test_speaker();
    int pulses;
    run_frame(1'b1, pulses);
    n_vec++;
    if (frame_done !== 1'b1 || spk_toggles !== 16'd5) begin
      n_err++;
      $display("FAIL spk_toggles: got %0d done=%0b want 5/1", spk_toggles, frame_done);
    end
  endtask

  task automatic test_short_line();
    int pulses;
    short_v = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 38) begin
        n_vec++;
        if (err_line !== 1'b0 || locked !== 1'b1) begin
          n_err++;
          $display("FAIL short_before: err_line=%0b locked=%0b want 0/1", err_line, locked);
        end
      end
    end
    n_vec++;
    if (err_line !== 1'b1 || locked !== 1'b0 || h_pos !== 10'(HT - 1) || v_pos !== 10'd1) begin
      n_err++;
      $display("FAIL short_detect: err_line=%0b locked=%0b h=%0d v=%0d want 1/0/19/1", err_line, locked, h_pos, v_pos);
    end
    step();
    n_vec++;
    if (h_pos !== 10'(HT - 1) || err_frame !== 1'b0) begin
      n_err++;
      $display("FAIL short_hunt_hold: h=%0d err_frame=%0b want 19/0", h_pos, err_frame);
    end
    short_v = -1;
    run_to_origin(pulses);
    run_frame(1'b0, pulses);
    n_vec++;
    if (locked !== 1'b1 || err_line !== 1'b1 || pulses != 1) begin
      n_err++;
      $display("FAIL short_relock: locked=%0b err_line=%0b pulses=%0d want 1/1/1", locked, err_line, pulses);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_vec++;
    if (err_line !== 1'b0) begin
      n_err++;
      $display("FAIL short_clear: err_line=%0b want 0", err_line);
    end
  endtask

  task automatic test_hsync_shift();
    int pulses;
    run_to_origin(pulses);
    hs_start = HSS + 1;
    for (int i = 0; i <= HSS; i++) begin
      step();
      if (i == HSS - 1) begin
        n_vec++;
        if (err_hsync !== 1'b0) begin
          n_err++;
          $display("FAIL hs_before: err_hsync=%0b want 0", err_hsync);
        end
      end
    end
    n_vec++;
    if (err_hsync !== 1'b1 || h_pos !== 10'(HSS) || locked !== 1'b0 || err_line !== 1'b0) begin
      n_err++;
      $display("FAIL hs_detect: err_hsync=%0b h=%0d locked=%0b err_line=%0b want 1/14/0/0", err_hsync, h_pos, locked, err_line);
    end
    hs_start = HSS;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_vec++;
    if (err_hsync !== 1'b0) begin
      n_err++;
      $display("FAIL hs_clear: err_hsync=%0b want 0", err_hsync);
    end
    run_to_origin(pulses);
    run_frame(1'b0, pulses);
    n_vec++;
    if (locked !== 1'b1 || err_hsync !== 1'b0) begin
      n_err++;
      $display("FAIL hs_relock: locked=%0b err_hsync=%0b want 1/0", locked, err_hsync);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    run_to_origin(pulses);
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({h_pos, v_pos, locked, frame_done, frame_count, frame_cksum, lit_count, spk_toggles,
         err_line, err_frame, err_hsync, err_vsync} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: h=%0d v=%0d locked=%0b fc=%0d lit=%0d want all 0", h_pos, v_pos, locked, frame_count, lit_count);
    end
    rst_n = 1'b1;
    run_to_origin(pulses);
    n_vec++;
    if (pulses != 0 || frame_count !== 8'd0) begin
      n_err++;
      $display("FAIL midreset_no_done: pulses=%0d fc=%0d want 0/0", pulses, frame_count);
    end
    run_frame(1'b0, pulses);
    n_vec++;
    if (pulses != 1 || frame_count !== 8'd1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_track: pulses=%0d fc=%0d locked=%0b want 1/1/1", pulses, frame_count, locked);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    gh = 5; gv = 3; rgb_mode = 0; hs_start = HSS; short_v = -1; spk_level = 1'b0;
    rst_n = 1'b0; clear_err = 1'b0; red = 1'b0; green = 1'b0; blue = 1'b0;
    hsync = 1'b1; vsync = 1'b1; col0 = 1'b0; row0 = 1'b0; speaker = 1'b0;
    @(negedge clk);
    test_reset();
    test_game();
    test_white_frame();
    test_speaker();
    test_short_line();
    test_hsync_shift();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
